// File: rtl/cgra_tile_dma_ctrl_if.sv
// Stream and tile-memory external-port signals of the tile DMA sequencer.
// master = the sequencer; slave = the stream endpoints and the tile memory.
interface cgra_tile_dma_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] ext_addr;
  logic [1:0]            ext_bank_sel;
  logic                  ext_read;
  logic                  ext_write;
  logic [DATA_WIDTH-1:0] ext_wdata;
  logic [DATA_WIDTH-1:0] ext_rdata;
  logic                  ext_valid;

  modport master (
    input  in_data, in_valid, out_ready, ext_rdata, ext_valid,
    output in_ready, out_data, out_valid,
    output ext_addr, ext_bank_sel, ext_read, ext_write, ext_wdata
  );

  modport slave (
    output in_data, in_valid, out_ready, ext_rdata, ext_valid,
    input  in_ready, out_data, out_valid,
    input  ext_addr, ext_bank_sel, ext_read, ext_write, ext_wdata
  );
endinterface

// File: rtl/cgra_tile_dma_ctrl.sv
// Burst sequencer owning the tile memory external port: stream->bank loads
// and bank->stream stores with programmable base, stride and length.
module cgra_tile_dma_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12,
  parameter int LEN_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start,
  input  logic                  cfg_dir,
  input  logic [1:0]            cfg_bank,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [ADDR_WIDTH-1:0] cfg_stride,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [LEN_WIDTH-1:0]  xfer_count,
  cgra_tile_dma_ctrl_if.master  bus
);

  typedef enum logic [2:0] {IDLE, LOAD, RD_REQ, RD_WAIT, OUT, FIN} state_t;

  state_t                state, state_d;
  logic [1:0]            bank_q;
  logic [ADDR_WIDTH-1:0] stride_q;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [LEN_WIDTH-1:0]  count_inc;
  logic                  advance;
  logic                  capture;

  assign count_inc = xfer_count + LEN_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      bank_q     <= '0;
      stride_q   <= '0;
      cur_addr   <= '0;
      len_q      <= '0;
      xfer_count <= '0;
      out_data_q <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE && cfg_start) begin
        bank_q     <= cfg_bank;
        stride_q   <= cfg_stride;
        cur_addr   <= cfg_base;
        len_q      <= cfg_len;
        xfer_count <= '0;
      end
      if (advance) begin
        xfer_count <= count_inc;
        cur_addr   <= cur_addr + stride_q;
      end
      if (capture) out_data_q <= bus.ext_rdata;
    end
  end

  // abort overrides every other event in a busy state, so each strobe and
  // handshake below is gated with !abort as well as the state decode.
  always_comb begin
    state_d = state;
    advance = 1'b0;
    capture = 1'b0;
    unique case (state)
      IDLE: begin
        if (cfg_start) begin
          if (cfg_len == '0) state_d = FIN;
          else if (cfg_dir)  state_d = RD_REQ;
          else               state_d = LOAD;
        end
      end
      LOAD: begin
        if (abort) state_d = IDLE;
        else if (bus.in_valid) begin
          advance = 1'b1;
          if (count_inc == len_q) state_d = FIN;
        end
      end
      RD_REQ: state_d = abort ? IDLE : RD_WAIT;
      RD_WAIT: begin
        if (abort) state_d = IDLE;
        else if (bus.ext_valid) begin
          capture = 1'b1;
          state_d = OUT;
        end
      end
      OUT: begin
        if (abort) state_d = IDLE;
        else if (bus.out_ready) begin
          advance = 1'b1;
          state_d = (count_inc == len_q) ? FIN : RD_REQ;
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state != IDLE);
  assign aborted = busy && abort;
  assign done    = (state == FIN) && !abort;

  assign bus.in_ready     = (state == LOAD) && !abort;
  assign bus.ext_write    = bus.in_ready && bus.in_valid;
  assign bus.ext_read     = (state == RD_REQ) && !abort;
  assign bus.out_valid    = (state == OUT) && !abort;
  assign bus.out_data     = out_data_q;
  assign bus.ext_addr     = cur_addr;
  assign bus.ext_bank_sel = bank_q;
  assign bus.ext_wdata    = bus.in_data;

endmodule

// File: tb/tb_cgra_tile_dma_ctrl.sv
// Scoreboard bench for the tile DMA sequencer with a behavioural tile memory.
module tb_cgra_tile_dma_ctrl;

  typedef struct packed {
    logic [1:0]  bank;
    logic [11:0] addr;
    logic [15:0] data;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_start, cfg_dir, abort;
  logic [1:0]  cfg_bank;
  logic [11:0] cfg_base, cfg_stride, cfg_len;
  logic        busy, done, aborted;
  logic [11:0] xfer_count;

  cgra_tile_dma_ctrl_if #(.DATA_WIDTH(16), .ADDR_WIDTH(12)) bus ();

  cgra_tile_dma_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(12), .LEN_WIDTH(12)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_dir(cfg_dir),
    .cfg_bank(cfg_bank), .cfg_base(cfg_base), .cfg_stride(cfg_stride),
    .cfg_len(cfg_len), .abort(abort), .busy(busy), .done(done),
    .aborted(aborted), .xfer_count(xfer_count), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:3][0:4095];
  logic        model_valid = 1'b0;
  logic [15:0] model_rdata = '0;
  logic        manual = 1'b0;
  logic        man_valid = 1'b0;
  logic [15:0] man_rdata = '0;

  always @(posedge clk) begin
    model_valid <= bus.ext_read;
    if (bus.ext_read) model_rdata <= mem[bus.ext_bank_sel][bus.ext_addr];
    if (bus.ext_write) mem[bus.ext_bank_sel][bus.ext_addr] <= bus.ext_wdata;
  end

  assign bus.ext_valid = manual ? man_valid : model_valid;
  assign bus.ext_rdata = manual ? man_rdata : model_rdata;

  acc_t        wr_q[$];
  acc_t        rd_q[$];
  logic [15:0] out_q[$];
  int checks = 0, failures = 0;
  int wr_seen = 0, rd_seen = 0, done_seen = 0, abort_seen = 0;

  // Observe one cycle at the falling edge, then return just after the next rising edge.
  task automatic sample();
    acc_t e, got;
    @(negedge clk);
    if (bus.ext_write) begin
      wr_seen++;
      checks++;
      got = '{bus.ext_bank_sel, bus.ext_addr, bus.ext_wdata};
      if (wr_q.size() == 0) begin
        failures++;
        $display("FAIL write_unexpected got=%h", got);
      end else begin
        e = wr_q.pop_front();
        if (got !== e) begin
          failures++;
          $display("FAIL write_access got=%h exp=%h", got, e);
        end
      end
    end
    if (bus.ext_read) begin
      rd_seen++;
      checks++;
      if (rd_q.size() == 0) begin
        failures++;
        $display("FAIL read_unexpected bank=%0d addr=%h", bus.ext_bank_sel, bus.ext_addr);
      end else begin
        e = rd_q.pop_front();
        if ({bus.ext_bank_sel, bus.ext_addr} !== {e.bank, e.addr}) begin
          failures++;
          $display("FAIL read_access got=%0d/%h exp=%0d/%h",
                   bus.ext_bank_sel, bus.ext_addr, e.bank, e.addr);
        end
      end
    end
    if (bus.ext_read && bus.ext_write) begin
      checks++;
      failures++;
      $display("FAIL strobe_exclusive read and write together");
    end
    if (bus.out_valid && bus.out_ready) begin
      checks++;
      if (out_q.size() == 0) begin
        failures++;
        $display("FAIL out_unexpected got=%h", bus.out_data);
      end else if (bus.out_data !== out_q[0]) begin
        failures++;
        $display("FAIL out_data got=%h exp=%h", bus.out_data, out_q[0]);
        void'(out_q.pop_front());
      end else begin
        void'(out_q.pop_front());
      end
    end
    if (done) done_seen++;
    if (aborted) abort_seen++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_load(input logic [1:0] b, input logic [11:0] base,
                          input logic [11:0] stride, input int len,
                          input int abort_at, input bit dup_start);
    logic [11:0] a;
    logic [15:0] d;
    cfg_dir = 1'b0; cfg_bank = b; cfg_base = base; cfg_stride = stride;
    cfg_len = 12'(len); cfg_start = 1'b1;
    sample();
    cfg_start = 1'b0;
    a = base;
    for (int i = 0; i < len; i++) begin
      d = 16'($urandom);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      if (i == abort_at) abort = 1'b1;
      else wr_q.push_back('{b, a, d});
      if (dup_start && i == 1) begin
        cfg_start = 1'b1; cfg_bank = 2'd3; cfg_base = 12'h300; cfg_len = 12'd1;
      end
      sample();
      cfg_start = 1'b0;
      abort = 1'b0;
      if (i == abort_at) break;
      a = a + stride;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sample();
    sample();
    rst_n = 1'b1;
    checks++;
    if ({busy, done, aborted, bus.in_ready, bus.out_valid, bus.ext_read, bus.ext_write} !== 7'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0", {busy, done, aborted, bus.in_ready,
               bus.out_valid, bus.ext_read, bus.ext_write});
    end
    checks++;
    if ({xfer_count, bus.out_data, bus.ext_addr, bus.ext_bank_sel} !== '0) begin
      failures++;
      $display("FAIL reset_regs count=%h out=%h addr=%h bank=%h",
               xfer_count, bus.out_data, bus.ext_addr, bus.ext_bank_sel);
    end
  endtask

  task automatic test_load4();
    int d0;
    d0 = done_seen;
    run_load(2'd2, 12'h010, 12'd1, 4, -1, 1'b0);
    checks++;
    if (done !== 1'b1 || xfer_count !== 12'd4) begin
      failures++;
      $display("FAIL load4_done done=%b count=%0d exp done=1 count=4", done, xfer_count);
    end
    sample();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || xfer_count !== 12'd4 || wr_q.size() != 0) begin
      failures++;
      $display("FAIL load4_end busy=%b done=%b count=%0d pending=%0d exp 0/0/4/0",
               busy, done, xfer_count, wr_q.size());
    end
    checks++;
    if (done_seen - d0 != 1) begin
      failures++;
      $display("FAIL load4_done_count got=%0d exp=1", done_seen - d0);
    end
  endtask

  task automatic test_store();
    int r0, d0, stall, cyc;
    logic [11:0] a;
    logic [15:0] v;
    r0 = rd_seen; d0 = done_seen;
    a = 12'h100;
    for (int i = 0; i < 3; i++) begin
      v = 16'h5A00 + 16'(i * 17);
      mem[1][a] = v;
      rd_q.push_back('{2'd1, a, 16'h0});
      out_q.push_back(v);
      a = a + 12'd4;
    end
    cfg_dir = 1'b1; cfg_bank = 2'd1; cfg_base = 12'h100; cfg_stride = 12'd4;
    cfg_len = 12'd3; cfg_start = 1'b1;
    sample();
    cfg_start = 1'b0;
    stall = 0;
    for (cyc = 0; cyc < 60; cyc++) begin
      if (done) break;
      if (bus.out_valid) begin
        if (stall < 2) begin
          bus.out_ready = 1'b0;
          stall++;
          checks++;
          if (out_q.size() == 0 || bus.out_data !== out_q[0]) begin
            failures++;
            $display("FAIL store_stall_stable got=%h exp=%h", bus.out_data,
                     (out_q.size() != 0) ? out_q[0] : 16'hxxxx);
          end
        end else begin
          bus.out_ready = 1'b1;
          stall = 0;
        end
      end else begin
        bus.out_ready = 1'b0;
      end
      sample();
    end
    bus.out_ready = 1'b0;
    checks++;
    if (done !== 1'b1 || xfer_count !== 12'd3) begin
      failures++;
      $display("FAIL store_done done=%b count=%0d exp done=1 count=3 (cycles=%0d)",
               done, xfer_count, cyc);
    end
    sample();
    checks++;
    if (rd_seen - r0 != 3 || out_q.size() != 0 || rd_q.size() != 0) begin
      failures++;
      $display("FAIL store_totals reads=%0d pend_out=%0d pend_rd=%0d exp 3/0/0",
               rd_seen - r0, out_q.size(), rd_q.size());
    end
    checks++;
    if (done_seen - d0 != 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL store_done_once dones=%0d busy=%b exp 1/0", done_seen - d0, busy);
    end
  endtask

  task automatic test_wrap_zero();
    int w0, r0;
    run_load(2'd0, 12'hFFE, 12'd1, 3, -1, 1'b0);
    checks++;
    if (done !== 1'b1 || xfer_count !== 12'd3 || wr_q.size() != 0) begin
      failures++;
      $display("FAIL wrap_done done=%b count=%0d pending=%0d exp 1/3/0",
               done, xfer_count, wr_q.size());
    end
    sample();
    w0 = wr_seen; r0 = rd_seen;
    cfg_dir = 1'b0; cfg_len = 12'd0; cfg_base = 12'h055; cfg_start = 1'b1;
    sample();
    cfg_start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || xfer_count !== 12'd0) begin
      failures++;
      $display("FAIL zero_len_done done=%b busy=%b count=%0d exp 1/1/0", done, busy, xfer_count);
    end
    sample();
    checks++;
    if (busy !== 1'b0 || wr_seen != w0 || rd_seen != r0) begin
      failures++;
      $display("FAIL zero_len_idle busy=%b writes=%0d reads=%0d exp 0/0/0",
               busy, wr_seen - w0, rd_seen - r0);
    end
  endtask

  task automatic test_abort_load();
    int w0, a0, d0;
    w0 = wr_seen; a0 = abort_seen; d0 = done_seen;
    run_load(2'd3, 12'h020, 12'd2, 8, 3, 1'b0);
    checks++;
    if (wr_seen - w0 != 3 || abort_seen - a0 != 1 || done_seen != d0) begin
      failures++;
      $display("FAIL abort_counts writes=%0d aborted=%0d done=%0d exp 3/1/0",
               wr_seen - w0, abort_seen - a0, done_seen - d0);
    end
    checks++;
    if (busy !== 1'b0 || xfer_count !== 12'd3 || aborted !== 1'b0) begin
      failures++;
      $display("FAIL abort_after busy=%b count=%0d aborted=%b exp 0/3/0",
               busy, xfer_count, aborted);
    end
  endtask

  task automatic test_start_busy();
    int d0;
    d0 = done_seen;
    run_load(2'd0, 12'h040, 12'd1, 4, -1, 1'b1);
    sample();
    checks++;
    if (done_seen - d0 != 1 || xfer_count !== 12'd4 || wr_q.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL start_busy dones=%0d count=%0d pending=%0d busy=%b exp 1/4/0/0",
               done_seen - d0, xfer_count, wr_q.size(), busy);
    end
  endtask

  task automatic test_reset_mid_store();
    int d0, a0;
    d0 = done_seen; a0 = abort_seen;
    manual = 1'b1;
    man_valid = 1'b0;
    rd_q.push_back('{2'd2, 12'h200, 16'h0});
    cfg_dir = 1'b1; cfg_bank = 2'd2; cfg_base = 12'h200; cfg_stride = 12'd1;
    cfg_len = 12'd2; cfg_start = 1'b1;
    sample();
    cfg_start = 1'b0;
    sample();
    checks++;
    if (busy !== 1'b1 || bus.ext_read !== 1'b0 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rd_wait_hold busy=%b read=%b out_valid=%b exp 1/0/0",
               busy, bus.ext_read, bus.out_valid);
    end
    rst_n = 1'b0;
    sample();
    rst_n = 1'b1;
    checks++;
    if ({busy, bus.ext_read, bus.ext_write, bus.out_valid, bus.in_ready} !== 5'b0 ||
        {xfer_count, bus.out_data, bus.ext_addr, bus.ext_bank_sel} !== '0) begin
      failures++;
      $display("FAIL reset_mid_store busy=%b rd=%b count=%h out=%h addr=%h bank=%h exp all 0",
               busy, bus.ext_read, xfer_count, bus.out_data, bus.ext_addr, bus.ext_bank_sel);
    end
    man_valid = 1'b1;
    man_rdata = 16'hBEEF;
    sample();
    man_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.out_data !== 16'h0) begin
      failures++;
      $display("FAIL late_valid out_valid=%b busy=%b out=%h exp 0/0/0",
               bus.out_valid, busy, bus.out_data);
    end
    checks++;
    if (done_seen != d0 || abort_seen != a0) begin
      failures++;
      $display("FAIL reset_no_pulse dones=%0d aborts=%0d exp 0/0",
               done_seen - d0, abort_seen - a0);
    end
    manual = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cfg_start = 1'b0; cfg_dir = 1'b0; abort = 1'b0;
    cfg_bank = '0; cfg_base = '0; cfg_stride = '0; cfg_len = '0;
    bus.in_data = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    #1;
    test_reset();
    test_load4();
    test_store();
    test_wrap_zero();
    test_abort_load();
    test_start_busy();
    test_reset_mid_store();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cgra_tile_dma_ctrl.md
Name: cgra_tile_dma_ctrl

Overview:
Sequencer that owns the external (DMA) port of the row-banked tile memory.
- Moves a programmed burst between a valid/ready stream and one bank.
- Load direction: stream → bank. Store direction: bank → stream.
- Supports a programmable base and stride.
- Sits between the host/NoC DMA front-end and the tile memory ext_* port. It is the only master of that port.

Parameters:
DATA_WIDTH, 16, word width; matches tile memory.
ADDR_WIDTH, 12, per-bank address width.
LEN_WIDTH, 12, width of burst length / transfer counter.

Ports:
clk  in  1  clock
rst_n  in  1  reset
cfg_start  in  1  one-cycle start pulse; sampled only in IDLE
cfg_dir  in  1  0 = load (stream→bank), 1 = store (bank→stream)
cfg_bank  in  2  target bank
cfg_base  in  ADDR_WIDTH  first word address
cfg_stride  in  ADDR_WIDTH  address increment per word
cfg_len  in  LEN_WIDTH  words to transfer
abort  in  1  cancel the active burst
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at normal burst completion
aborted  out  1  one-cycle pulse when a burst is cancelled
xfer_count  out  LEN_WIDTH  words completed in current/last burst
in_data  in  DATA_WIDTH  load stream data
in_valid  in  1  load stream valid
in_ready  out  1  load stream ready
out_data  out  DATA_WIDTH  store stream data
out_valid  out  1  store stream valid
out_ready  in  1  store stream ready
ext_addr  out  ADDR_WIDTH  tile memory ext address
ext_bank_sel  out  2  tile memory bank select
ext_read  out  1  tile memory read strobe
ext_write  out  1  tile memory write strobe
ext_wdata  out  DATA_WIDTH  tile memory write data
ext_rdata  in  DATA_WIDTH  tile memory read data
ext_valid  in  1  tile memory read valid (1 cycle after ext_read)

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset state: state=IDLE.
- Reset values: busy, done, aborted, in_ready, out_valid, ext_read and ext_write are all 0. xfer_count, out_data and the address/bank registers are all 0.
- States: IDLE, LOAD, RD_REQ, RD_WAIT, OUT, FIN.
- IDLE + cfg_start:
  - Latch bank, base, stride and len.
  - Set cur_addr=base and xfer_count=0.
  - If len==0, go to FIN. Otherwise go to LOAD (dir=0) or RD_REQ (dir=1).
- LOAD:
  - in_ready=1.
  - ext_write = in_valid, combinational; ext_wdata=in_data; ext_addr=cur_addr; ext_bank_sel=latched bank.
  - On each in_valid: xfer_count+1 and cur_addr+=stride.
  - When xfer_count reaches len, go to FIN.
  - Rate: one word per cycle.
- RD_REQ: ext_read=1 for exactly one cycle at cur_addr, then go to RD_WAIT.
- RD_WAIT: on ext_valid, capture ext_rdata into out_data and go to OUT. Without ext_valid, hold in RD_WAIT with no reissue.
- OUT:
  - out_valid=1; out_data is held stable until accepted.
  - On out_ready: xfer_count+1 and cur_addr+=stride. Go to FIN if the count now equals len, else go to RD_REQ.
  - Rate: at most one word per 3 cycles.
- FIN: done=1 for one cycle, then go to IDLE. xfer_count holds its final value until the next start.
- Address arithmetic: cur_addr+stride is modulo 2^ADDR_WIDTH (wraps silently). Stride 0 is legal and repeatedly accesses one address.
- ext_read and ext_write are never asserted together. Both are 0 in IDLE and FIN.
- in_ready=0 and out_valid=0 outside LOAD and OUT respectively.
- abort, in any non-IDLE state, takes priority over every other event that cycle:
  - no ext_write/handshake counted that cycle;
  - next state is IDLE; aborted=1 for one cycle; done is not pulsed;
  - xfer_count keeps words completed before the abort cycle;
  - a read data beat returning after the abort is ignored.
- abort in IDLE: no effect.
- cfg_start while busy: ignored; configuration registers are unchanged.
- Reset mid-burst: immediate return to reset values next edge; no done/aborted pulse.

Test Plan:
- Load 4 words: bank=2, base=0x010, stride=1, len=4; in_valid held high with data A0..A3 → ext_write on 4 consecutive cycles at addrs 0x010–0x013 with bank_sel=2. done one cycle after the last write; xfer_count=4.
- Store with backpressure: bank=1, base=0x100, stride=4, len=3; out_ready low 2 cycles per word → ext_read at 0x100, 0x104, 0x108 with one read each. out_data equals memory contents and is stable while stalled; done pulses once.
- Wrap and zero length: base=0xFFE, stride=1, len=3 load → addrs 0xFFE, 0xFFF, 0x000. A separate start with len=0 → done one cycle later, no ext strobes.
- Abort mid-load: len=8; abort asserted with in_valid on the 4th word → only 3 writes occur. aborted=1 and done=0; xfer_count=3; busy=0 next cycle.
- Start while busy: second cfg_start with bank=3 issued during an active bank=0 burst → ignored. All accesses stay on bank 0 and exactly one done pulse.
- Synchronous reset mid-store (in RD_WAIT): rst_n low one cycle → all outputs 0, state IDLE. A late ext_valid produces no out_valid.
